alu_sub_seq: RTL

- Parametrised, registered successor to the accumulator datapath's ALU subsystem.
- Selects the A operand from PC/ACC/SP and the B operand from constant/SE/MDR/ZE/SL1, then executes one operation per Start request.
- Adds multi-cycle barrel-free shifts and a shift-add multiply, a Start/Busy/Done handshake and a registered NZCV flag set.
- Driven by the control FSM, which waits on Done before consuming Out.

---
 rtl/alu_sub_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_sub_seq.sv
// Sequential ALU: operand muxing, Start/Busy/Done handshake, multi-cycle shifts and
// shift-add multiply, with a registered result and NZCV flags.
module alu_sub_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BCONST = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_sp,
  input  logic [WIDTH-1:0] i_mdr,
  input  logic [WIDTH-1:0] i_se,
  input  logic [WIDTH-1:0] i_ze,
  input  logic [WIDTH-1:0] i_sl1,
  input  logic [1:0]       i_src_a,
  input  logic [2:0]       i_src_b,
  input  logic [3:0]       i_alu_op,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNor  = 4'd5;
  localparam logic [3:0] OpSlt  = 4'd6;
  localparam logic [3:0] OpPassB = 4'd7;
  localparam logic [3:0] OpSll  = 4'd8;
  localparam logic [3:0] OpSrl  = 4'd9;
  localparam logic [3:0] OpSra  = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [3:0]       r_op;
  logic [SW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SW-1:0]    w_n;
  logic [SW-1:0]    w_cnt_init;
  logic             w_op_shift;
  logic             w_r_shift;
  logic             w_shz;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_bit;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  always_comb begin
    case (i_src_a)
      2'd0:    w_a = i_pc;
      2'd1:    w_a = i_acc;
      2'd2:    w_a = i_sp;
      default: w_a = '0;
    endcase
    case (i_src_b)
      3'd0:    w_b = WIDTH'(BCONST);
      3'd1:    w_b = i_se;
      3'd2:    w_b = i_mdr;
      3'd3:    w_b = i_ze;
      3'd4:    w_b = i_sl1;
      default: w_b = '0;
    endcase
  end

  // Counter holds remaining EXEC cycles minus one; shift by 0 still takes one cycle.
  always_comb begin
    w_n        = w_b[SW-1:0];
    w_op_shift = (i_alu_op >= OpSll) && (i_alu_op <= OpSra);
    w_cnt_init = '0;
    if (w_op_shift && (w_n != '0)) begin
      w_cnt_init = w_n - 1'b1;
    end else if (i_alu_op == OpMul) begin
      w_cnt_init = SW'(WIDTH - 1);
    end
  end

  always_comb begin
    w_r_shift = (r_op >= OpSll) && (r_op <= OpSra);
    w_shz     = (r_b[SW-1:0] == '0);
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_diff    = {1'b0, r_a} - {1'b0, r_b};
    w_mul_sum = {1'b0, r_hi} + {1'b0, {WIDTH{r_b[0]}} & r_a};
    case (r_op)
      OpSll: begin
        w_sh_next = {r_a[WIDTH-2:0], 1'b0};
        w_sh_bit  = r_a[WIDTH-1];
      end
      OpSrl: begin
        w_sh_next = {1'b0, r_a[WIDTH-1:1]};
        w_sh_bit  = r_a[0];
      end
      default: begin
        w_sh_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        w_sh_bit  = r_a[0];
      end
    endcase
  end

  always_comb begin
    w_res = r_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OpAdd: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpSub: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpAnd:   w_res = r_a & r_b;
      OpOr:    w_res = r_a | r_b;
      OpXor:   w_res = r_a ^ r_b;
      OpNor:   w_res = ~(r_a | r_b);
      OpSlt:   w_res = {{(WIDTH-1){1'b0}}, $signed(r_a) < $signed(r_b)};
      OpPassB: w_res = r_b;
      OpSll, OpSrl, OpSra: begin
        w_res = w_shz ? r_a : w_sh_next;
        w_c   = ~w_shz & w_sh_bit;
      end
      OpMul: begin
        w_res = {w_mul_sum[0], r_b[WIDTH-1:1]};
        w_c   = |w_mul_sum[WIDTH:1];
      end
      default: w_res = r_a;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= i_alu_op;
            r_cnt   <= w_cnt_init;
            r_hi    <= '0;
            r_busy  <= 1'b1;
            r_state <= StExec;
          end else begin
            r_state <= StIdle;
          end
        end
        StExec: begin
          if (w_r_shift && !w_shz) begin
            r_a <= w_sh_next;
          end
          // Shift-add: {r_hi, r_b} shifts right while partial sums accumulate in r_hi.
          if (r_op == OpMul) begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_b  <= {w_mul_sum[0], r_b[WIDTH-1:1]};
          end
          if (r_cnt == '0) begin
            r_out   <= w_res;
            r_zero  <= (w_res == '0);
            r_neg   <= w_res[WIDTH-1];
            r_carry <= w_c;
            r_ovf   <= w_v;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_out   = r_out;
  assign o_zero  = r_zero;
  assign o_neg   = r_neg;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;

endmodule
